// File: rtl/uart_rx_depacketizer.sv
// rtl/uart_rx_depacketizer.sv - UART 8N1 receiver with mid-bit sampling, valid/ready byte output and error pulses.
// Optional 8E1/8O1 parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_depacketizer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx_depacketizer: CLKS_PER_BIT must be even and >= 4, PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t           state, state_n;
    logic             sync_q1, sync_q2;
    logic             rx_s;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift_q, shift_n;
    logic [7:0]       data_q, data_n;
    logic             valid_q, valid_n;
    logic             frame_q, frame_n;
    logic             overrun_q, overrun_n;
    logic             deliver;
    logic             accept;

`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_n;
    logic             parity_q, parity_n;
`endif

    assign rx_s = sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= 1'b1;
            sync_q2   <= 1'b1;
            state     <= S_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            parity_q  <= 1'b0;
`endif
        end else begin
            sync_q1   <= serial_in;
            sync_q2   <= sync_q1;
            state     <= state_n;
            clk_cnt   <= clk_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift_q   <= shift_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            frame_q   <= frame_n;
            overrun_q <= overrun_n;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_n;
            parity_q  <= parity_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt + 1'b1;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_q;
        frame_n   = 1'b0;
        deliver   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad_q;
        parity_n  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = 3'd0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_n = '0;
                    // A start bit that is high again at its centre was only a glitch.
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_n = '0;
                    shift_n   = {rx_s, shift_q[7:1]};
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_n = '0;
                    par_bad_n = rx_s != (^shift_q ^ (PARITY_ODD != 0));
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_n = '0;
                    if (!rx_s) begin
                        frame_n = 1'b1;
                        state_n = S_WAIT_IDLE;
                    end else begin
                        state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            parity_n = 1'b1;
                        end else begin
                            deliver = 1'b1;
                        end
`else
                        deliver = 1'b1;
`endif
                    end
                end
            end
            S_WAIT_IDLE: begin
                clk_cnt_n = '0;
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                clk_cnt_n = '0;
                state_n   = S_IDLE;
            end
        endcase
    end

    // Output holding register: a same-cycle accept frees the slot for the new byte.
    always_comb begin
        accept    = valid_q & data_out_ready;
        data_n    = data_q;
        valid_n   = valid_q & ~accept;
        overrun_n = 1'b0;
        if (deliver) begin
            if (!valid_q || accept) begin
                data_n  = shift_q;
                valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign rx_busy        = (state != S_IDLE);
    assign frame_err      = frame_q;
    assign overrun        = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err     = parity_q;
`else
    assign parity_err     = 1'b0;
`endif

endmodule
